// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logical/shift execution unit.
package logic_unit_pkg;

  localparam int LU_OP_W = 3;

  // Operation codes understood by logic_unit_core.
  typedef enum logic [LU_OP_W-1:0] {
    LU_AND = 3'b000,
    LU_OR  = 3'b001,
    LU_XOR = 3'b010,
    LU_NOR = 3'b011,
    LU_LUI = 3'b100,
    LU_SLL = 3'b101,
    LU_SRL = 3'b110,
    LU_SRA = 3'b111
  } lu_op_t;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational logical/shift datapath: computes result and zero flag for one op.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  lu_op_t         op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   result,
  output logic           zero
);

  localparam int SH_W = $clog2(N);

  // Only the low SH_W bits of b steer the shifter; the rest are ignored.
  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  // Select the operation result.
  always_comb begin
    result = '0;
    case (op)
      LU_AND: result = a & b;
      LU_OR:  result = a | b;
      LU_XOR: result = a ^ b;
      LU_NOR: result = ~(a | b);
      LU_LUI: result = {b[N/2-1:0], {(N/2){1'b0}}};
      LU_SLL: result = a << shamt;
      LU_SRL: result = a >> shamt;
      LU_SRA: result = $unsigned($signed(a) >>> shamt);
    endcase
  end

  assign zero = ~|result;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logical/shift unit with valid/ready handshakes and flush.
// S1 holds the raw operands, S2 holds the computed result; out_* come straight from S2.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int N     = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LU_OP_W-1:0] in_op,
  input  logic [N-1:0]       in_a,
  input  logic [N-1:0]       in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_result,
  output logic               out_zero,
  output logic [TAG_W-1:0]   out_tag
);

  // Stage 1 registers (operands)
  logic               s1_valid_reg;
  lu_op_t             s1_op_reg;
  logic [N-1:0]       s1_a_reg;
  logic [N-1:0]       s1_b_reg;
  logic [TAG_W-1:0]   s1_tag_reg;

  // Stage 2 registers (result)
  logic               s2_valid_reg;
  logic [N-1:0]       s2_result_reg;
  logic               s2_zero_reg;
  logic [TAG_W-1:0]   s2_tag_reg;

  // Core outputs feeding S2
  logic [N-1:0]       core_result;
  logic               core_zero;

  // Pipeline advance chain: a stage may move when it is empty or its successor moves.
  logic s2_adv;
  logic s1_adv;
  logic in_fire;

  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv && !flush;
  assign in_fire  = in_valid && in_ready;

  logic_unit_core #(
    .N (N)
  ) u_core (
    .op     (s1_op_reg),
    .a      (s1_a_reg),
    .b      (s1_b_reg),
    .result (core_result),
    .zero   (core_zero)
  );

  // Stage valid bits: reset beats flush, flush beats normal advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (s1_adv) s1_valid_reg <= in_fire;
      if (s2_adv) s2_valid_reg <= s1_valid_reg;
    end
  end

  // S1 operand capture; loads only on an accepted op so idle inputs never disturb it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_op_reg  <= LU_AND;
      s1_a_reg   <= '0;
      s1_b_reg   <= '0;
      s1_tag_reg <= '0;
    end else if (in_fire) begin
      s1_op_reg  <= lu_op_t'(in_op);
      s1_a_reg   <= in_a;
      s1_b_reg   <= in_b;
      s1_tag_reg <= in_tag;
    end
  end

  // S2 result capture; held while the consumer stalls so out_* stay stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_result_reg <= '0;
      s2_zero_reg   <= 1'b0;
      s2_tag_reg    <= '0;
    end else if (!flush && s2_adv && s1_valid_reg) begin
      s2_result_reg <= core_result;
      s2_zero_reg   <= core_zero;
      s2_tag_reg    <= s1_tag_reg;
    end
  end

  assign out_valid  = s2_valid_reg;
  assign out_result = s2_result_reg;
  assign out_zero   = s2_zero_reg;
  assign out_tag    = s2_tag_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (N=32, TAG_W=5).
module tb_logic_unit_pipe;

  localparam int N     = 32;
  localparam int TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_result;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  int total;
  int bad;

  logic_unit_pipe #(
    .N     (N),
    .TAG_W (TAG_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [TAG_W-1:0] tag);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  task automatic idle();
    drive(1'b0, 3'bxxx, 'x, 'x, 'x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    idle();
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", out_result); end
    total++; if (out_tag !== 5'd0) begin bad++; $display("FAIL reset_tag: got %0d want 0", out_tag); end
    total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL reset_zero: got %b want 0", out_zero); end
    rst_n = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick();
    $display("reset done");
  endtask

  // One isolated op: accept, result visible two edges later, then pipeline empties.
  task automatic run_vec(input string name, input logic [2:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [TAG_W-1:0] tag,
                         input logic [N-1:0] exp_res, input logic exp_zero);
    out_ready = 1'b1;
    drive(1'b1, op, a, b, tag);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready); end
    tick();
    idle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_early: out_valid got %b want 0", name, out_valid); end
    tick();
    $display("op %s tag=%0d result=%h zero=%b", name, out_tag, out_result, out_zero);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_valid: got %b want 1", name, out_valid); end
    total++; if (out_result !== exp_res) begin bad++; $display("FAIL %s_result: got %h want %h", name, out_result, exp_res); end
    total++; if (out_zero !== exp_zero) begin bad++; $display("FAIL %s_zero: got %b want %b", name, out_zero, exp_zero); end
    total++; if (out_tag !== tag) begin bad++; $display("FAIL %s_tag: got %0d want %0d", name, out_tag, tag); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_drain: out_valid got %b want 0", name, out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd3);
    tick();
    drive(1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready: got %b want 1", in_ready); end
    tick();
    idle();
    $display("stream tag=%0d result=%h zero=%b", out_tag, out_result, out_zero);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_and_valid: got %b want 1", out_valid); end
    total++; if (out_result !== 32'h00F0_1234) begin bad++; $display("FAIL stream_and_result: got %h want 00f01234", out_result); end
    total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL stream_and_zero: got %b want 0", out_zero); end
    total++; if (out_tag !== 5'd3) begin bad++; $display("FAIL stream_and_tag: got %0d want 3", out_tag); end
    tick();
    $display("stream tag=%0d result=%h zero=%b", out_tag, out_result, out_zero);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_nor_valid: got %b want 1", out_valid); end
    total++; if (out_result !== 32'h0) begin bad++; $display("FAIL stream_nor_result: got %h want 00000000", out_result); end
    total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL stream_nor_zero: got %b want 1", out_zero); end
    total++; if (out_tag !== 5'd7) begin bad++; $display("FAIL stream_nor_tag: got %0d want 7", out_tag); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_ops();
    run_vec("or",      3'b001, 32'hF0F0_0000, 32'h0000_1234, 5'd1,  32'hF0F0_1234, 1'b0);
    run_vec("xor",     3'b010, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd2,  32'hF0F0_0F0F, 1'b0);
    run_vec("xor_z",   3'b010, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 5'd4,  32'h0000_0000, 1'b1);
    run_vec("sra",     3'b111, 32'h8000_0000, 32'h0000_0024, 5'd10, 32'hF800_0000, 1'b0);
    run_vec("srl",     3'b110, 32'h8000_0000, 32'h0000_0024, 5'd11, 32'h0800_0000, 1'b0);
    run_vec("sll",     3'b101, 32'h0000_0001, 32'h0000_001F, 5'd12, 32'h8000_0000, 1'b0);
    run_vec("lui",     3'b100, 32'h0000_0000, 32'h1234_ABCD, 5'd13, 32'hABCD_0000, 1'b0);
    run_vec("sra_pos", 3'b111, 32'h7000_0000, 32'h0000_0004, 5'd14, 32'h0700_0000, 1'b0);
    run_vec("sra_31",  3'b111, 32'h8000_0000, 32'h0000_001F, 5'd15, 32'hFFFF_FFFF, 1'b0);
    run_vec("srl_hib", 3'b110, 32'h8000_0000, 32'hFFFF_FFE4, 5'd16, 32'h0800_0000, 1'b0);
    run_vec("sll_0",   3'b101, 32'h1234_5678, 32'hFFFF_FFE0, 5'd17, 32'h1234_5678, 1'b0);
    run_vec("sll_out", 3'b101, 32'h8000_0000, 32'h0000_0001, 5'd18, 32'h0000_0000, 1'b1);
  endtask

  // OR with b=0 makes the result equal to the tag value, so ordering is visible in both.
  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 32'd1, 32'd0, 5'd1);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_c0: got %b want 1", in_ready); end
    tick();
    drive(1'b1, 3'b001, 32'd2, 32'd0, 5'd2);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_c1: got %b want 1", in_ready); end
    tick();
    drive(1'b1, 3'b001, 32'd3, 32'd0, 5'd3);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c2: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b1 || out_tag !== 5'd1) begin bad++; $display("FAIL bp_head: valid=%b tag=%0d want valid=1 tag=1", out_valid, out_tag); end
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c3: got %b want 0", in_ready); end
    total++; if (out_result !== 32'd1 || out_tag !== 5'd1) begin bad++; $display("FAIL bp_hold: result=%h tag=%0d want 00000001 tag=1", out_result, out_tag); end
    tick();
    total++; if (out_result !== 32'd1 || out_tag !== 5'd1 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold2: valid=%b result=%h tag=%0d want 1/00000001/1", out_valid, out_result, out_tag); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    idle();
    $display("bp out tag=%0d result=%h", out_tag, out_result);
    total++; if (out_valid !== 1'b1 || out_tag !== 5'd2 || out_result !== 32'd2) begin bad++; $display("FAIL bp_out2: valid=%b tag=%0d result=%h want 1/2/00000002", out_valid, out_tag, out_result); end
    tick();
    $display("bp out tag=%0d result=%h", out_tag, out_result);
    total++; if (out_valid !== 1'b1 || out_tag !== 5'd3 || out_result !== 32'd3) begin bad++; $display("FAIL bp_out3: valid=%b tag=%0d result=%h want 1/3/00000003", out_valid, out_tag, out_result); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 32'd4, 32'd0, 5'd4);
    tick();
    drive(1'b1, 3'b001, 32'd5, 32'd0, 5'd5);
    tick();
    drive(1'b1, 3'b001, 32'd6, 32'd0, 5'd6);
    flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_kill: out_valid got %b tag=%0d want 0", out_valid, out_tag); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_after_ready: got %b want 1", in_ready); end
    tick();
    idle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_stale: out_valid got %b tag=%0d want 0", out_valid, out_tag); end
    out_ready = 1'b1;
    tick();
    $display("flush out tag=%0d result=%h", out_tag, out_result);
    total++; if (out_valid !== 1'b1 || out_tag !== 5'd6 || out_result !== 32'd6) begin bad++; $display("FAIL flush_tag6: valid=%b tag=%0d result=%h want 1/6/00000006", out_valid, out_tag, out_result); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(1'b1, 3'b001, 32'hDEAD_0008, 32'd0, 5'd8);
    tick();
    drive(1'b1, 3'b001, 32'hBEEF_0009, 32'd0, 5'd9);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    $display("reset mid valid=%b tag=%0d result=%h zero=%b", out_valid, out_tag, out_result, out_zero);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    total++; if (out_result !== 32'h0) begin bad++; $display("FAIL rmid_result: got %h want 00000000", out_result); end
    total++; if (out_tag !== 5'd0) begin bad++; $display("FAIL rmid_tag: got %0d want 0", out_tag); end
    total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL rmid_zero: got %b want 0", out_zero); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale%0d: out_valid got %b tag=%0d want 0", i, out_valid, out_tag); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    idle();
    test_reset();
    test_stream();
    test_ops();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
